// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq -- register-access sequencer in front of the I2C byte master.
// Turns one host request (device address, register address, optional write
// data) into the START / address / register / data / STOP byte-command stream
// and returns one done pulse carrying status and read data.
//
// Host side : req, req_rw, dev_addr, reg_addr, wdata -> busy, done, err_code, rdata
// Master side: m_go, m_start, m_stop, m_rw, m_data   <- m_ack, m_nack, m_to, m_rdata
//
// Optional build macro I2C_RETRY_EN: an address NACK triggers STOP and a
// restart from the write-address byte, up to RETRY_MAX times.
module i2c_reg_seq #(
  parameter int unsigned STOP_CYCLES = 600,
  parameter int unsigned WDOG_CYCLES = 4000000,
  parameter int unsigned RETRY_MAX   = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req,
  input  logic       req_rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [1:0] err_code,
  output logic [7:0] rdata,
  output logic       m_go,
  output logic       m_start,
  output logic       m_stop,
  output logic       m_rw,
  output logic [7:0] m_data,
  input  logic       m_ack,
  input  logic       m_nack,
  input  logic       m_to,
  input  logic [7:0] m_rdata
);

  localparam int unsigned CNT_MAX = (WDOG_CYCLES > STOP_CYCLES) ? WDOG_CYCLES : STOP_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  if (STOP_CYCLES < 1 || WDOG_CYCLES < 2 || RETRY_MAX > 15) begin : g_param_check
    $error("i2c_reg_seq: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_W, S_REG, S_WDATA, S_ADDR_R, S_RDATA, S_STOP, S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic          issue_q, issue_d;   // 1 = ISSUE phase, 0 = WAIT phase
  logic [CW-1:0] cnt_q, cnt_d;       // watchdog in byte states, STOP delay in S_STOP
  logic          rw_q, rw_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [1:0]    err_q, err_d;
  logic [7:0]    rdata_q, rdata_d;
`ifdef I2C_RETRY_EN
  logic [3:0]    retry_q, retry_d;
  logic          restart_q, restart_d;  // the STOP in progress is followed by a restart
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      issue_q   <= 1'b0;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
`ifdef I2C_RETRY_EN
      retry_q   <= '0;
      restart_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      issue_q   <= issue_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
`ifdef I2C_RETRY_EN
      retry_q   <= retry_d;
      restart_q <= restart_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    issue_d   = issue_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
`ifdef I2C_RETRY_EN
    retry_d   = retry_q;
    restart_d = restart_q;
`endif
    busy    = 1'b0;
    done    = 1'b0;
    m_go    = 1'b0;
    m_start = 1'b0;
    m_stop  = 1'b0;
    m_rw    = 1'b0;
    m_data  = '0;

    // Command fields depend only on state, so they stay stable through WAIT.
    case (state_q)
      S_ADDR_W: begin m_start = 1'b1; m_data = {dev_q, 1'b0}; end
      S_REG:    m_data = reg_q;
      S_WDATA:  m_data = wdata_q;
      S_ADDR_R: begin m_start = 1'b1; m_data = {dev_q, 1'b1}; end
      S_RDATA:  m_rw = 1'b1;
      S_STOP:   m_stop = 1'b1;
      default:  ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (req) begin
          rw_d    = req_rw;
          dev_d   = dev_addr;
          reg_d   = reg_addr;
          wdata_d = wdata;
          err_d   = '0;
          state_d = S_ADDR_W;
          issue_d = 1'b1;
`ifdef I2C_RETRY_EN
          retry_d   = '0;
          restart_d = 1'b0;
`endif
        end
      end

      S_ADDR_W, S_REG, S_WDATA, S_ADDR_R, S_RDATA: begin
        busy = 1'b1;
        if (issue_q) begin
          m_go    = 1'b1;
          issue_d = 1'b0;
          cnt_d   = '0;
        end else if (m_to || cnt_q == CW'(WDOG_CYCLES - 1)) begin
          // Master is already back in its wait state: no STOP.
          err_d   = 2'd3;
          state_d = S_FIN;
        end else if (m_nack) begin
          state_d = S_STOP;
          issue_d = 1'b1;
          if (state_q == S_ADDR_W || state_q == S_ADDR_R) begin
`ifdef I2C_RETRY_EN
            if (retry_q < 4'(RETRY_MAX)) begin
              retry_d   = retry_q + 4'd1;
              restart_d = 1'b1;
            end else begin
              err_d = 2'd1;
            end
`else
            err_d = 2'd1;
`endif
          end else begin
            err_d = 2'd2;
          end
        end else if (m_ack) begin
          issue_d = 1'b1;
          case (state_q)
            S_ADDR_W: state_d = S_REG;
            S_REG:    state_d = rw_q ? S_ADDR_R : S_WDATA;
            S_ADDR_R: state_d = S_RDATA;
            S_RDATA: begin
              rdata_d = m_rdata;
              state_d = S_STOP;
            end
            default:  state_d = S_STOP;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        busy = 1'b1;
        if (issue_q) begin
          m_go    = 1'b1;
          issue_d = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == CW'(STOP_CYCLES - 1)) begin
`ifdef I2C_RETRY_EN
          if (restart_q) begin
            restart_d = 1'b0;
            state_d   = S_ADDR_W;
            issue_d   = 1'b1;
          end else begin
            state_d = S_FIN;
          end
`else
          state_d = S_FIN;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    err_code = err_q;
    rdata    = rdata_q;
  end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Self-checking bench for i2c_reg_seq: a scripted byte-master responder
// drives ACK/NACK/timeout replies, and a transaction-level model predicts the
// command stream, status, read data and completion latency.
module tb_i2c_reg_seq;

  localparam int unsigned STOP_C = 20;
  localparam int unsigned WDOG_C = 100;
  localparam int unsigned RMAX   = 2;
`ifdef I2C_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req = 1'b0, req_rw = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0, wdata = '0;
  logic       busy, done, m_go, m_start, m_stop, m_rw;
  logic [1:0] err_code;
  logic [7:0] rdata, m_data;
  logic       m_ack = 1'b0, m_nack = 1'b0, m_to = 1'b0;
  logic [7:0] m_rdata = '0;

  always #5 clock = ~clock;

  i2c_reg_seq #(.STOP_CYCLES(STOP_C), .WDOG_CYCLES(WDOG_C), .RETRY_MAX(RMAX)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_rw(req_rw),
    .dev_addr(dev_addr), .reg_addr(reg_addr), .wdata(wdata),
    .busy(busy), .done(done), .err_code(err_code), .rdata(rdata),
    .m_go(m_go), .m_start(m_start), .m_stop(m_stop), .m_rw(m_rw), .m_data(m_data),
    .m_ack(m_ack), .m_nack(m_nack), .m_to(m_to), .m_rdata(m_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef enum int {R_ACK, R_NACK, R_TO, R_NONE} rk_t;
  typedef struct {
    rk_t         kind;
    logic [7:0]  data;
    int unsigned dly;
    bit          both;   // also raise lower-priority responses in the same cycle
  } resp_t;

  resp_t      plan[$];
  logic [10:0] exp_cmds[$];  // {start, stop, rw, data}
  logic [1:0] exp_err;
  int         exp_lat;       // FIN cycles after last go, -1 = not checked
  logic [7:0] rdata_model = '0;

  localparam logic [10:0] STOP_CMD = 11'b010_0000_0000;

  function automatic resp_t rand_resp();
    resp_t r;
    int unsigned p = $urandom_range(0, 99);
    r.kind = (p < 82) ? R_ACK : (p < 91) ? R_NACK : (p < 97) ? R_TO : R_NONE;
    r.data = 8'($urandom);
    r.dly  = $urandom_range(1, 5);
    r.both = 1'($urandom);
    return r;
  endfunction

  task automatic set_plan(input rk_t k0, input rk_t k1, input rk_t k2, input rk_t k3);
    rk_t ks[4];
    ks = '{k0, k1, k2, k3};
    plan.delete();
    for (int i = 0; i < 16; i++) begin
      resp_t r = rand_resp();
      r.kind = (i < 4) ? ks[i] : R_ACK;
      plan.push_back(r);
    end
  endtask

  task automatic rand_plan();
    plan.delete();
    for (int i = 0; i < 16; i++) plan.push_back(rand_resp());
  endtask

  // Transaction-level prediction from the request and the scripted replies.
  task automatic build_expect(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                              input logic [7:0] wd);
    logic [10:0] seq[$];
    resp_t r;
    int pi, retries;
    bit fin, restart, is_addr;
    pi = 0; retries = 0; fin = 0;
    exp_cmds.delete();
    exp_lat = -1;
    exp_err = 2'd0;
    while (!fin) begin
      seq.delete();
      seq.push_back({3'b100, dev, 1'b0});
      seq.push_back({3'b000, rg});
      if (rw) begin
        seq.push_back({3'b100, dev, 1'b1});
        seq.push_back(11'b001_0000_0000);
      end else begin
        seq.push_back({3'b000, wd});
      end
      restart = 0;
      for (int i = 0; i < seq.size(); i++) begin
        r = plan[pi];
        pi++;
        exp_cmds.push_back(seq[i]);
        is_addr = (i == 0) || (rw && i == 2);
        if (r.kind == R_ACK) begin
          if (rw && i == 3) rdata_model = r.data;
        end else if (r.kind == R_NACK) begin
          exp_cmds.push_back(STOP_CMD);
          exp_lat = int'(STOP_C) + 1;
          if (is_addr && RETRY_ON && retries < int'(RMAX)) begin
            retries++;
            restart = 1;
          end else begin
            exp_err = is_addr ? 2'd1 : 2'd2;
            fin = 1;
          end
          break;
        end else begin
          exp_err = 2'd3;
          if (r.kind == R_NONE) exp_lat = int'(WDOG_C) + 1;
          fin = 1;
          break;
        end
      end
      if (!fin && !restart) begin
        exp_cmds.push_back(STOP_CMD);
        exp_lat = int'(STOP_C) + 1;
        fin = 1;
      end
    end
  endtask

  task automatic run_txn(input string nm, input logic rw, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [7:0] wd, input int abort_go);
    logic [10:0] got[$];
    logic [10:0] cur_cmd, last;
    resp_t cur;
    int pi, cd, since, cyc, ngo, stable_bad, abort_cnt;
    bit fin;
    pi = 0; cd = -1; since = 0; cyc = 0; ngo = 0; stable_bad = 0; abort_cnt = -1;
    fin = 0; last = '0;
    build_expect(rw, dev, rg, wd);
    @(negedge clock);
    req = 1'b1; req_rw = rw; dev_addr = dev; reg_addr = rg; wdata = wd;
    while (!fin && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      req = 1'b0;
      m_ack = 1'b0; m_nack = 1'b0; m_to = 1'b0;
      if (cyc == 1) check_eq({nm, "_busy_on"}, {31'd0, busy}, 32'd1);
      if (abort_cnt > 0) begin
        abort_cnt--;
        if (abort_cnt == 0) begin
          reset_n = 1'b0;
          #1;
          check_eq({nm, "_async_rst"},
                   {9'd0, busy, done, err_code, rdata, m_go, m_start, m_stop, m_rw, m_data}, 32'd0);
          rdata_model = '0;
          @(negedge clock);
          reset_n = 1'b1;
          return;
        end
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          case (cur.kind)
            R_ACK:   m_ack = 1'b1;
            R_NACK:  begin m_nack = 1'b1; m_ack = cur.both; end
            default: begin m_to = 1'b1; m_nack = cur.both; m_ack = cur.both; end
          endcase
          m_rdata = cur.data;
          cd = -1;
        end
      end
      cur_cmd = {m_start, m_stop, m_rw, m_data};
      if (m_go) begin
        got.push_back(cur_cmd);
        last = cur_cmd;
        ngo++;
        since = 0;
        if (!m_stop) begin
          cur = plan[pi];
          pi++;
          cd = (cur.kind == R_NONE) ? -1 : int'(cur.dly);
        end
        if (abort_go != 0 && ngo == abort_go) abort_cnt = 3;
      end else begin
        since++;
        if (busy && cur_cmd !== last) stable_bad++;
      end
      // Stray responses while the STOP delay runs must be ignored.
      if (busy && !m_go && cd < 0 && last[9] && $urandom_range(0, 5) == 0) begin
        m_ack = 1'($urandom);
        m_nack = ~m_ack;
        m_rdata = 8'($urandom);
      end
      // Requests while busy must be ignored.
      if (busy && $urandom_range(0, 3) == 0) begin
        req = 1'b1; req_rw = 1'($urandom); dev_addr = 7'($urandom);
        reg_addr = 8'($urandom); wdata = 8'($urandom);
      end
      if (done) begin
        fin = 1;
        req = 1'b0;
        check_eq({nm, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check_eq({nm, "_err"}, {30'd0, err_code}, {30'd0, exp_err});
        check_eq({nm, "_rdata"}, {24'd0, rdata}, {24'd0, rdata_model});
        check_eq({nm, "_ngo"}, got.size(), exp_cmds.size());
        for (int i = 0; i < got.size() && i < exp_cmds.size(); i++)
          check_eq($sformatf("%s_cmd%0d", nm, i), {21'd0, got[i]}, {21'd0, exp_cmds[i]});
        check_eq({nm, "_stable"}, stable_bad, 0);
        if (exp_lat >= 0) check_eq({nm, "_latency"}, since, exp_lat);
      end
    end
    if (!fin) begin
      check_eq({nm, "_done_timeout"}, 0, 1);
    end else begin
      @(negedge clock);
      check_eq({nm, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
      check_eq({nm, "_err_hold"}, {30'd0, err_code}, {30'd0, exp_err});
    end
  endtask

  task automatic idle_gap();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      m_ack = 1'($urandom); m_nack = 1'($urandom); m_to = 1'b0;
      m_rdata = 8'($urandom);
    end
    @(negedge clock);
    m_ack = 1'b0; m_nack = 1'b0;
    check_eq("idle_ignore", {30'd0, busy, m_go}, 32'd0);
  endtask

  initial begin
    #200_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (3) @(negedge clock);
    check_eq("reset_outs",
             {9'd0, busy, done, err_code, rdata, m_go, m_start, m_stop, m_rw, m_data}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("reset_idle", {30'd0, busy, m_go}, 32'd0);

    set_plan(R_ACK, R_ACK, R_ACK, R_ACK);
    run_txn("wr_ok", 1'b0, 7'h50, 8'h10, 8'hA5, 0);
    idle_gap();

    set_plan(R_ACK, R_ACK, R_ACK, R_ACK);
    plan[3].data = 8'h3C;
    run_txn("rd_ok", 1'b1, 7'h50, 8'h22, 8'h00, 0);
    idle_gap();

    set_plan(R_ACK, R_NACK, R_ACK, R_ACK);
    run_txn("wr_regnack", 1'b0, 7'h50, 8'h10, 8'h5A, 0);
    idle_gap();

    set_plan(R_NONE, R_ACK, R_ACK, R_ACK);
    run_txn("wdog", 1'b0, 7'h50, 8'h10, 8'h5A, 0);
    idle_gap();

    set_plan(R_ACK, R_ACK, R_ACK, R_NONE);
    run_txn("rd_abort", 1'b1, 7'h33, 8'h44, 8'h00, 4);
    set_plan(R_ACK, R_ACK, R_ACK, R_ACK);
    run_txn("after_rst", 1'b1, 7'h12, 8'h34, 8'h00, 0);
    idle_gap();

    plan.delete();
    for (int i = 0; i < 16; i++) begin
      resp_t r = rand_resp();
      r.kind = (i < 3) ? R_NACK : R_ACK;
      r.both = 1'b0;
      plan.push_back(r);
    end
    run_txn("addr_nack", 1'b0, 7'h2A, 8'h01, 8'h02, 0);
    idle_gap();

    for (int t = 0; t < 40; t++) begin
      rand_plan();
      run_txn($sformatf("rnd%0d", t), 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 0);
      idle_gap();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_reg_seq.md
Name: i2c_reg_seq

Overview:
- Register-access sequencer sitting directly upstream of the I2C byte-level master.
- Turns one host request (device address, register address, optional write data) into the ordered byte-command stream the master consumes, using START, STOP, RW, dataW and a `go` pulse.
- Collects the master's ACK/NACK/timeout responses and read data, then returns one completion pulse with status to the host.

Parameters:
- STOP_CYCLES, 600, clocks to wait after issuing a STOP before completing (covers the master's 500-cycle SDA release).
- WDOG_CYCLES, 4000000, maximum clocks waiting for any single byte response before declaring timeout.
- RETRY_MAX, 3, address-NACK retries (used only with I2C_RETRY_EN).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  1  host request strobe, sampled only in IDLE
- req_rw  in  1  0 = register write, 1 = register read
- dev_addr  in  7  7-bit slave address
- reg_addr  in  8  register index
- wdata  in  8  write data
- busy  out  1  high from request accept until done
- done  out  1  one-cycle completion pulse
- err_code  out  2  0 = ok, 1 = address NACK, 2 = reg/data NACK, 3 = timeout; valid with done
- rdata  out  8  read result; valid with done when req_rw=1 and err_code=0
- m_go  out  1  one-cycle command pulse to master
- m_start  out  1  command: generate START/repeated START before byte
- m_stop  out  1  command: generate STOP
- m_rw  out  1  command: 0 write byte, 1 read byte
- m_data  out  8  byte to transmit
- m_ack  in  1  master: byte acknowledged / read byte complete
- m_nack  in  1  master: byte not acknowledged
- m_to  in  1  master: clock-stretch timeout pulse
- m_rdata  in  8  master read data, valid with m_ack in read phase

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy=0, done=0, err_code=0, rdata=0, m_go=0, m_start=0, m_stop=0, m_rw=0, m_data=0; counters cleared. Reset mid-transaction abandons the bus without a STOP.
- Request latch: in IDLE, req=1 latches req_rw, dev_addr, reg_addr and wdata; busy=1 the next cycle. req is ignored while busy.
- States: IDLE -> ADDR_W -> REG -> (write: WDATA | read: ADDR_R -> RDATA) -> STOP -> FIN -> IDLE.
- Byte states have two phases:
  - ISSUE: exactly one cycle with m_go=1 and command fields set.
  - WAIT: m_go=0, fields held stable, until a response arrives.
- Command fields per state:
  - ADDR_W: m_start=1, m_rw=0, m_data={dev_addr,0}.
  - REG: m_start=0, m_data=reg_addr.
  - WDATA: m_data=wdata.
  - ADDR_R: m_start=1 (repeated START), m_data={dev_addr,1}.
  - RDATA: m_rw=1; on m_ack, capture m_rdata into rdata.
- Response priority in WAIT: m_to > m_nack > m_ack.
  - m_ack: advance to next state's ISSUE on the following cycle.
  - m_nack in ADDR_W/ADDR_R: record err 1 -> STOP.
  - m_nack in REG/WDATA: record err 2 -> STOP.
  - m_to: record err 3 -> FIN directly (no STOP; the master has already returned to its wait state).
- Watchdog: counter cleared on each ISSUE and incremented in WAIT. Reaching WDOG_CYCLES-1 behaves as m_to (err 3).
- STOP: one ISSUE cycle with m_go=1, m_stop=1, then wait STOP_CYCLES clocks.
- FIN: done=1 for one cycle with err_code and rdata stable; busy=0 the same cycle. Next cycle is IDLE.
- err_code holds its value until the next accepted request clears it. rdata is updated only on a successful read byte.
- Minimum latency req -> done: 1 + per-byte (1 ISSUE + response time) + 1 + STOP_CYCLES + 1.
- Simultaneous m_ack and m_nack is resolved as NACK.
- Spurious m_ack/m_nack in IDLE or STOP is ignored.

Optional Feature:
- Macro I2C_RETRY_EN.
- Defined: m_nack in ADDR_W or ADDR_R issues STOP, waits STOP_CYCLES, then restarts from ADDR_W. A retry counter (clears on accept) allows up to RETRY_MAX restarts; after the final NACK, err 1 is reported as normal. Retries are invisible to the host apart from latency.
- Undefined: no retry logic or counter; the first address NACK terminates with err 1.

Test Plan:
- Write, dev 0x50, reg 0x10, wdata 0xA5, model ACKs each byte -> m_data sequence 0xA0, 0x10, 0xA5 then STOP; done with err 0; exactly four m_go pulses.
- Read, dev 0x50, reg 0x22, model returns 0x3C -> m_data 0xA0, 0x22, then 0xA1 with m_start=1, then read with m_rw=1, then STOP; done with rdata 0x3C, err 0.
- Write with NACK on reg byte -> STOP issued, done with err 2, no WDATA go pulse.
- Model never responds to the first byte (WDOG_CYCLES=100) -> done with err 3 exactly 100 cycles after WAIT entry; no STOP pulse.
- reset_n asserted low during RDATA wait -> all outputs 0 immediately; a new req after release completes normally.
- With I2C_RETRY_EN, RETRY_MAX=2, address NACKed 3 times -> three address ISSUEs, three STOPs, done with err 1. Without the macro -> one ISSUE, err 1.
